// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-drain pull-low enables
// ports: clk/reset sync active-high; ps2Clk/ps2Data debounced line levels; txByte/txValid/txReady
// byte handshake; busy high outside IDLE; ps2ClkLow/ps2DataLow pull-low enables; done pulse with
// ackErr (no ack from device) and timeoutErr (watchdog abort)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 3000,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    input  logic [7:0] txByte,
    input  logic       txValid,
    output logic       txReady,
    output logic       busy,
    output logic       ps2ClkLow,
    output logic       ps2DataLow,
    output logic       done,
    output logic       ackErr,
    output logic       timeoutErr
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;
    state_t state;
    logic clk_prev, ack_err_l, fall, wd_on, wd_hit;
    logic [9:0] frame;
    logic [3:0] bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [WW-1:0] wd;
    assign fall = clk_prev & ~ps2Clk;
    assign wd_on = state == RTS || state == SEND || state == ACK || state == WAIT_IDLE;
    assign wd_hit = wd_on && wd == WW'(TIMEOUT_CYCLES);
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            clk_prev   <= 1'b1;
            ack_err_l  <= 1'b0;
            frame      <= '0;
            bit_cnt    <= '0;
            inh_cnt    <= '0;
            wd         <= '0;
            txReady    <= 1'b1;
            busy       <= 1'b0;
            ps2ClkLow  <= 1'b0;
            ps2DataLow <= 1'b0;
            done       <= 1'b0;
            ackErr     <= 1'b0;
            timeoutErr <= 1'b0;
        end else begin
            clk_prev   <= ps2Clk;
            done       <= 1'b0;
            ackErr     <= 1'b0;
            timeoutErr <= 1'b0;
            // watchdog restarts on every device clock fall and saturates at the limit
            if (wd_on) wd <= fall ? '0 : (wd_hit ? wd : wd + 1'b1);
            if (wd_hit) begin
                state      <= IDLE;
                txReady    <= 1'b1;
                busy       <= 1'b0;
                ps2ClkLow  <= 1'b0;
                ps2DataLow <= 1'b0;
                done       <= 1'b1;
                timeoutErr <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (txValid) begin
                        frame     <= {1'b1, ~^txByte, txByte};
                        inh_cnt   <= IW'(INHIBIT_CYCLES - 1);
                        state     <= INHIBIT;
                        txReady   <= 1'b0;
                        busy      <= 1'b1;
                        ps2ClkLow <= 1'b1;
                    end
                    INHIBIT: if (inh_cnt == '0) begin
                        state      <= RTS;
                        ps2DataLow <= 1'b1;
                        wd         <= '0;
                    end else begin
                        inh_cnt <= inh_cnt - 1'b1;
                    end
                    RTS: begin
                        state     <= SEND;
                        ps2ClkLow <= 1'b0;
                        bit_cnt   <= '0;
                    end
                    // falls 1..9 present d0..d7 and parity; fall 10 releases data as the stop bit
                    SEND: if (fall) begin
                        if (bit_cnt <= 4'd8) begin
                            ps2DataLow <= ~frame[0];
                            frame      <= {1'b0, frame[9:1]};
                            bit_cnt    <= bit_cnt + 1'b1;
                        end else begin
                            ps2DataLow <= 1'b0;
                            state      <= ACK;
                        end
                    end
                    ACK: if (fall) begin
                        ack_err_l <= ps2Data;
                        state     <= WAIT_IDLE;
                    end
                    WAIT_IDLE: if (ps2Clk && ps2Data) begin
                        state   <= IDLE;
                        txReady <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        ackErr  <= ack_err_l;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model with line-bit and done-status scoreboards for ps2_host_tx
module tb_ps2_host_tx;
    localparam int I = 20;
    localparam int T = 2000;
    localparam int H = 10;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic [7:0] txByte = '0;
    logic txValid = 1'b0;
    logic ps2Clk, ps2Data, txReady, busy, ps2ClkLow, ps2DataLow, done, ackErr, timeoutErr;
    int chk_cnt = 0;
    int pass_cnt = 0;
    int stray = 0;
    logic exp_bits[$];
    logic [1:0] exp_done[$];
    logic [1:0] e;
    typedef struct {
        logic [7:0] b;
        bit ack;
        bit exp_ack_err;
    } vec_t;
    vec_t vecs[4];
    assign ps2Clk = dev_clk & ~ps2ClkLow;
    assign ps2Data = dev_data & ~ps2DataLow;
    always #5 clk = ~clk;
    ps2_host_tx #(.INHIBIT_CYCLES(I), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .ps2Clk(ps2Clk), .ps2Data(ps2Data),
        .txByte(txByte), .txValid(txValid), .txReady(txReady), .busy(busy),
        .ps2ClkLow(ps2ClkLow), .ps2DataLow(ps2DataLow), .done(done),
        .ackErr(ackErr), .timeoutErr(timeoutErr)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    task automatic push_frame(input logic [7:0] b, input int n);
        logic seq[11];
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[i+1] = b[i];
        seq[9] = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        seq[10] = 1'b1;
        for (int i = 0; i < n; i++) exp_bits.push_back(seq[i]);
    endtask
    task automatic sample_bit();
        logic b;
        b = exp_bits.size() != 0 ? exp_bits.pop_front() : 1'bx;
        chk("line_bit", ps2Data, b);
    endtask
    task automatic start_tx(input logic [7:0] b);
        int n = 0;
        while (!txReady && n < 20000) begin @(negedge clk); n++; end
        chk("ready_wait", txReady, 1);
        txByte = b;
        txValid = 1'b1;
        @(negedge clk);
        txValid = 1'b0;
    endtask
    task automatic device_xfer(input bit ack, input int n_falls);
        int n = 0;
        while (!(ps2Clk && ps2DataLow) && n < 5000) begin @(negedge clk); n++; end
        chk("start_wait", ps2Clk && ps2DataLow, 1);
        repeat (H) @(negedge clk);
        sample_bit();
        for (int i = 1; i <= n_falls; i++) begin
            if (i == 11 && ack) begin
                dev_data = 1'b0;
                repeat (2) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            if (i == n_falls && n_falls < 11) return;
            dev_clk = 1'b1;
            if (i <= 10) sample_bit();
            repeat (H) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask
    always @(negedge clk) begin
        if (done) begin
            if (exp_done.size() == 0) begin
                chk("unexpected_done", done, 0);
            end else begin
                e = exp_done.pop_front();
                chk("done_ack_err", ackErr, e[1]);
                chk("done_timeout_err", timeoutErr, e[0]);
            end
            chk("done_ready_lines", {txReady, busy, ps2ClkLow, ps2DataLow}, 4'b1000);
        end else if (ackErr || timeoutErr) begin
            stray++;
        end
    end
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1);
    end
    initial begin
        int n, cl, dl;
        vecs[0] = '{8'hED, 1'b1, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h7F, 1'b1, 1'b0};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_state", {txReady, busy, ps2ClkLow, ps2DataLow, done, ackErr, timeoutErr}, 7'b1000000);
        foreach (vecs[k]) begin
            push_frame(vecs[k].b, 11);
            exp_done.push_back({vecs[k].exp_ack_err, 1'b0});
            start_tx(vecs[k].b);
            device_xfer(vecs[k].ack, 11);
        end
        push_frame(8'h00, 11);
        exp_done.push_back(2'b00);
        push_frame(8'h01, 11);
        exp_done.push_back(2'b00);
        n = 0;
        while (!txReady && n < 20000) begin @(negedge clk); n++; end
        txByte = 8'h00;
        txValid = 1'b1;
        @(negedge clk);
        txByte = 8'h01;
        chk("b2b_busy_first", busy, 1);
        device_xfer(1'b1, 11);
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        chk("b2b_ready_gap", txReady, 1);
        @(negedge clk);
        chk("b2b_second_accepted", busy, 1);
        txValid = 1'b0;
        device_xfer(1'b1, 11);
        exp_done.push_back(2'b01);
        start_tx(8'h42);
        n = 0;
        while (ps2ClkLow && n < 200) begin @(negedge clk); n++; end
        chk("to_clk_released", {ps2ClkLow, ps2DataLow}, 2'b01);
        n = 0;
        while (!done && n < T + 50) begin @(negedge clk); n++; end
        chk("to_cycles_after_release", n, T);
        push_frame(8'h5A, 11);
        exp_done.push_back(2'b00);
        start_tx(8'h5A);
        chk("inh_busy_ready", {busy, txReady}, 2'b10);
        cl = 0;
        dl = -1;
        while (ps2ClkLow && cl < 200) begin
            cl++;
            if (ps2DataLow && dl < 0) dl = cl;
            if (cl == 5) begin txByte = 8'h11; txValid = 1'b1; end
            if (cl == 6) txValid = 1'b0;
            @(negedge clk);
        end
        chk("inh_clk_low_cycles", cl, I + 1);
        chk("inh_rts_cycle", dl, I + 1);
        device_xfer(1'b1, 11);
        push_frame(8'hEF, 5);
        start_tx(8'hEF);
        device_xfer(1'b1, 5);
        chk("rst_pre_data_low", ps2DataLow, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_released", {ps2ClkLow, ps2DataLow, busy, txReady, done}, 5'b00010);
        reset = 1'b0;
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        push_frame(8'hFF, 11);
        exp_done.push_back(2'b00);
        start_tx(8'hFF);
        device_xfer(1'b1, 11);
        repeat (50) @(negedge clk);
        chk("pending_done", exp_done.size(), 0);
        chk("pending_bits", exp_bits.size(), 0);
        chk("stray_err_flags", stray, 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the SoC to the keyboard over the same debounced ps2Clk/ps2Data lines that the keyboard receiver uses. It drives the lines open-drain through two "pull low" enables, which the top level maps onto tristate pads. It also sequences the full inhibit / request-to-send / clocked-data / acknowledge exchange.

## Interface
- INHIBIT_CYCLES, default 3000: clk cycles the clock line is held low before request-to-send. Must be ≥100 µs at the clk frequency.
- TIMEOUT_CYCLES, default 400000: maximum clk cycles between consecutive device clock falling edges, or waiting for bus idle, before the transfer aborts.
- clk  in  1  system clock (SoC clock domain). The block uses only this clock.
- reset  in  1  synchronous, active-high reset.
- ps2Clk  in  1  debounced PS/2 clock line level.
- ps2Data  in  1  debounced PS/2 data line level.
- txByte  in  8  byte to send. Sampled when txValid & txReady.
- txValid  in  1  send request.
- txReady  out  1  high only in IDLE.
- busy  out  1  high in every state except IDLE. The SoC uses it to gate the receiver.
- ps2ClkLow  out  1  1 = drive the clock line low, 0 = release it.
- ps2DataLow  out  1  1 = drive the data line low, 0 = release it.
- done  out  1  one-cycle pulse when a transfer ends, whether it succeeds or fails.
- ackErr  out  1  valid with done: the device did not pull data low in the ack slot.
- timeoutErr  out  1  valid with done: the transfer was aborted by the watchdog.

## Operation
- Falling-edge detect: register ps2Clk into clkPrev. fall = clkPrev & ~ps2Clk. clkPrev resets to 1.
- Frame shift register, 10 bits: {stop=1, parity, d7..d0}. parity is odd: ~^txByte. It is loaded on accept and shifted out LSB first.
- State machine:
  - IDLE: both lines released, txReady=1. On txValid: latch the frame, load the counter with INHIBIT_CYCLES-1, go to INHIBIT.
  - INHIBIT: ps2ClkLow=1, ps2DataLow=0. When the counter reaches 0, go to RTS.
  - RTS: one cycle with ps2ClkLow=1 and ps2DataLow=1 (start bit). Then go to SEND with ps2ClkLow=0, ps2DataLow=1, bitCnt=0.
  - SEND: on each fall:
    - If bitCnt ≤ 8: ps2DataLow = ~frame[0], shift the frame, bitCnt++. This covers d0..d7 and parity on falls 1..9.
    - On fall 10 (bitCnt=9): ps2DataLow=0 (stop bit, line released), go to ACK.
  - ACK: on the next fall, sample ps2Data. ackErr_l = ps2Data. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until ps2Clk=1 and ps2Data=1 in the same cycle. Then pulse done with ackErr=ackErr_l and go to IDLE.
- Watchdog: a 19-bit-capable counter, cleared on entry to RTS and on every fall. In RTS, SEND, ACK and WAIT_IDLE, reaching TIMEOUT_CYCLES causes:
  - both lines released next cycle,
  - done=1 with timeoutErr=1 and ackErr=0,
  - return to IDLE.
- txValid while busy is ignored. No queueing; txByte is not re-sampled.
- reset in any state:
  - next cycle state=IDLE and both lines released (bus freed mid-frame),
  - no done pulse,
  - frame and counters cleared.

## Timing
- Reset values: txReady=1, busy=0, ps2ClkLow=0, ps2DataLow=0, done=0, ackErr=0, timeoutErr=0.
- All outputs are registered.
- Accept edge N:
  - busy=1 and ps2ClkLow=1 from N+1.
  - ps2DataLow=1 at cycle N+1+INHIBIT_CYCLES.
  - The clock line is released one cycle later.
- A data bit is updated one cycle after the clk edge at which fall is detected. This is well inside the device's clock-low half period.
- ackErr and timeoutErr are meaningful only while done=1. Otherwise they are 0.
- done and txReady rise in the same cycle. A new txValid may be accepted in that cycle.
- Arithmetic:
  - bitCnt is 4 bits, range 0..9, and never wraps.
  - The inhibit counter counts down and must be wide enough for INHIBIT_CYCLES.
  - The watchdog saturates at TIMEOUT_CYCLES.

## Test plan
- Send 0xED, device model clocks at 12.5 kHz and acks. Data line seen at rising edges must be 0,1,0,1,1,0,1,1,1, parity 1, stop 1. Then done=1, ackErr=0, timeoutErr=0.
- Send 0x00 then 0x01 back-to-back, with the second txValid held during the first frame. The second is accepted only once txReady=1 after the first done. Parity must be 1 for 0x00 and 0 for 0x01.
- Device never pulls data low in the ack slot -> done=1, ackErr=1. Lines released, txReady=1.
- Device never clocks after RTS -> after exactly TIMEOUT_CYCLES: done=1, timeoutErr=1, ps2ClkLow=ps2DataLow=0.
- Assert reset after fall 5 of a frame -> next cycle ps2DataLow=0, busy=0, done never pulses. A new 0xFF transfer then completes with ackErr=0.
- Inhibit length check: ps2ClkLow is high for exactly INHIBIT_CYCLES+1 cycles before the clock line is released. txValid pulsed during INHIBIT is ignored.
